// File: rtl/mult_share_arbiter.sv
// Round-robin front end for one shared 4x4 array multiplier.
// One request in flight: accept, multiply, return with requester ID.
module four_bit_multiplier (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [3:0] pp [4];
   logic [4:0] acc [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pp[i] = a & {4{b[i]}};
      end
   end

   // Each row adds the next partial product to the upper bits of the last.
   always_comb begin
      acc[0] = {1'b0, pp[0]};
      for (int i = 1; i < 4; i++) begin
         acc[i] = {1'b0, acc[i-1][4:1]} + {1'b0, pp[i]};
      end
      p = {acc[3][4:1], acc[3][0], acc[2][0], acc[1][0], acc[0][0]};
   end

endmodule

module mult_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [4*N_REQ-1:0]          req_a,
   input  logic [4*N_REQ-1:0]          req_b,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(N_REQ)-1:0]    rsp_id,
   output logic [7:0]                  rsp_product,
   output logic                        busy,
   output logic [CNT_W-1:0]            op_count
);

   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    id_r;
   logic [3:0]         op_a;
   logic [3:0]         op_b;
   logic [7:0]         mul_p;

   logic [2*N_REQ-1:0] rv_dbl;
   logic [N_REQ-1:0]   rv_rot;
   logic [ID_W-1:0]    off;
   logic [ID_W:0]      gsum;
   logic [ID_W-1:0]    grant_id;
   logic               grant_found;
   logic [N_REQ-1:0]   grant_oh;
   logic [3:0]         sel_a;
   logic [3:0]         sel_b;
   logic               accept;
   logic               rsp_done;
   logic [ID_W-1:0]    rr_nxt;

   four_bit_multiplier u_mul (
      .a (op_a),
      .b (op_b),
      .p (mul_p)
   );

   // Rotate requests so bit 0 is rr_ptr, pick lowest set bit, rotate back.
   always_comb begin
      rv_dbl      = {req_valid, req_valid};
      rv_rot      = rv_dbl[N_REQ-1:0];
      rv_rot      = N_REQ'(rv_dbl >> rr_ptr);
      off         = '0;
      grant_found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rv_rot[k]) begin
            off         = ID_W'(k);
            grant_found = 1'b1;
         end
      end
      gsum = {1'b0, rr_ptr} + {1'b0, off};
      if (gsum >= (ID_W+1)'(N_REQ)) begin
         gsum = gsum - (ID_W+1)'(N_REQ);
      end
      grant_id = gsum[ID_W-1:0];
      grant_oh = N_REQ'(1) << grant_id;
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_a = req_a[4*i +: 4];
            sel_b = req_b[4*i +: 4];
         end
      end
   end

   always_comb begin
      if (id_r == ID_W'(N_REQ - 1)) begin
         rr_nxt = '0;
      end else begin
         rr_nxt = id_r + ID_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (grant_found) state_nxt = MUL;
         MUL:  state_nxt = RSP;
         RSP:  if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept    = (state == IDLE) && grant_found && !rst;
      rsp_valid = (state == RSP);
      rsp_done  = rsp_valid && rsp_ready;
      busy      = (state != IDLE);
      req_ready = accept ? grant_oh : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a <= '0;
         op_b <= '0;
         id_r <= '0;
      end else if (accept) begin
         op_a <= sel_a;
         op_b <= sel_b;
         id_r <= grant_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_product <= '0;
         rsp_id      <= '0;
      end else if (state == MUL) begin
         rsp_product <= mul_p;
         rsp_id      <= id_r;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         op_count <= '0;
      end else if (rsp_done) begin
         rr_ptr <= rr_nxt;
         if (op_count != {CNT_W{1'b1}}) begin
            op_count <= op_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: table of single ops plus
// hand sequences for backpressure, fairness, reset and exhaustive products.
module tb_mult_share_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_product;
   logic        busy;
   logic [15:0] op_count;

   logic [3:0]  s_ready;
   logic        s_valid;
   logic [1:0]  s_id;
   logic [7:0]  s_product;
   logic        s_busy;
   logic [1:0]  s_count;

   int checks;
   int failures;

   typedef struct {
      logic [3:0]  rv;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  er;
      logic [1:0]  eid;
      logic [7:0]  ep;
   } vec_t;

   vec_t tv [11];

   mult_share_arbiter #(.N_REQ(4), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .busy        (busy),
      .op_count    (op_count)
   );

   // Narrow counter copy to reach saturation quickly.
   mult_share_arbiter #(.N_REQ(4), .CNT_W(2)) u_sat (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (s_ready),
      .rsp_valid   (s_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (s_id),
      .rsp_product (s_product),
      .busy        (s_busy),
      .op_count    (s_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Starts and ends on a negedge in IDLE; rsp_ready held high.
   task automatic do_op(input logic [3:0] rv, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] er,
                        input logic [1:0] eid, input logic [7:0] ep,
                        input string nm);
      req_valid = rv;
      req_a = a;
      req_b = b;
      rsp_ready = 1'b1;
      #1;
      chk({nm, "_ready"}, req_ready, er);
      @(negedge clk);
      chk({nm, "_mul_ready"}, req_ready, 0);
      chk({nm, "_mul_valid"}, rsp_valid, 0);
      chk({nm, "_mul_busy"}, busy, 1);
      @(negedge clk);
      chk({nm, "_valid"}, rsp_valid, 1);
      chk({nm, "_id"}, rsp_id, eid);
      chk({nm, "_prod"}, rsp_product, ep);
      @(negedge clk);
      chk({nm, "_done"}, rsp_valid, 0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      tv[0]  = '{4'b0100, 16'h0700, 16'h0900, 4'b0100, 2'd2, 8'h3F};
      tv[1]  = '{4'b1111, 16'h4321, 16'h3333, 4'b1000, 2'd3, 8'd12};
      tv[2]  = '{4'b1111, 16'h4321, 16'h3333, 4'b0001, 2'd0, 8'd3};
      tv[3]  = '{4'b1111, 16'h4321, 16'h3333, 4'b0010, 2'd1, 8'd6};
      tv[4]  = '{4'b1111, 16'h4321, 16'h3333, 4'b0100, 2'd2, 8'd9};
      tv[5]  = '{4'b0011, 16'h00F5, 16'h00F2, 4'b0001, 2'd0, 8'd10};
      tv[6]  = '{4'b0011, 16'h00F5, 16'h00F2, 4'b0010, 2'd1, 8'hE1};
      tv[7]  = '{4'b0001, 16'h0000, 16'h000F, 4'b0001, 2'd0, 8'd0};
      tv[8]  = '{4'b1000, 16'hF000, 16'hF000, 4'b1000, 2'd3, 8'hE1};
      tv[9]  = '{4'b0110, 16'h0180, 16'h0180, 4'b0010, 2'd1, 8'd64};
      tv[10] = '{4'b0110, 16'h0180, 16'h0180, 4'b0100, 2'd2, 8'd1};

      rst = 1'b1;
      req_valid = 4'b1111;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      #3;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", op_count, 0);
      chk("rst_prod", rsp_product, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_sat", s_count, 0);
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 11; i++) begin
         do_op(tv[i].rv, tv[i].a, tv[i].b, tv[i].er, tv[i].eid,
               tv[i].ep, $sformatf("vec%0d", i));
      end
      req_valid = '0;
      chk("table_count", op_count, 11);
      chk("sat_count", s_count, 3);

      do_reset();
      req_valid = 4'b1111;
      req_a = 16'h4321;
      req_b = 16'h3333;
      rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         chk($sformatf("all4_ready_c%0d", c), req_ready,
             (c % 3 == 0) ? (32'd1 << (c / 3)) : 32'd0);
         chk($sformatf("all4_valid_c%0d", c), rsp_valid, (c % 3 == 2));
         if (c % 3 == 2) begin
            chk($sformatf("all4_id_c%0d", c), rsp_id, c / 3);
            chk($sformatf("all4_prod_c%0d", c), rsp_product, 3 * (c / 3 + 1));
         end
         @(negedge clk);
      end
      req_valid = '0;
      chk("all4_count", op_count, 4);

      do_reset();
      for (int k = 0; k < 6; k++) begin
         do_op(4'b0011, 16'h0042, 16'h0053,
               (k % 2 == 1) ? 4'b0010 : 4'b0001, 2'(k % 2),
               (k % 2 == 1) ? 8'd20 : 8'd6, $sformatf("fair%0d", k));
      end

      req_valid = 4'b0001;
      req_a = 16'h000F;
      req_b = 16'h000F;
      rsp_ready = 1'b0;
      #1;
      chk("bp_accept", req_ready, 4'b0001);
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_valid%0d", c), rsp_valid, 1);
         chk($sformatf("bp_prod%0d", c), rsp_product, 8'hE1);
         chk($sformatf("bp_id%0d", c), rsp_id, 0);
         chk($sformatf("bp_ready%0d", c), req_ready, 0);
         chk($sformatf("bp_count%0d", c), op_count, 6);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      chk("bp_last_valid", rsp_valid, 1);
      @(negedge clk);
      chk("bp_released", rsp_valid, 0);
      chk("bp_count", op_count, 7);

      req_valid = 4'b0100;
      req_a = 16'h0300;
      req_b = 16'h0300;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk("rr_in_rsp", rsp_valid, 1);
      #2;
      rst = 1'b1;
      req_valid = 4'b1001;
      #1;
      chk("rr_valid", rsp_valid, 0);
      chk("rr_busy", busy, 0);
      chk("rr_count", op_count, 0);
      chk("rr_prod", rsp_product, 0);
      chk("rr_ready", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      do_op(4'b1001, 16'h0006, 16'h0007, 4'b0001, 2'd0, 8'd42, "after_rst");
      req_valid = '0;
      chk("after_rst_count", op_count, 1);

      do_reset();
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_op(4'b0010, 16'(a << 4), 16'(b << 4), 4'b0010, 2'd1,
                  8'(a * b), $sformatf("ex_%0d_%0d", a, b));
         end
      end
      req_valid = '0;
      chk("ex_count", op_count, 256);
      chk("ex_sat", s_count, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
